line_buffer_sched: RTL and testbench
====================================

// Module: line_buffer_sched
// PURPOSE
//   Scheduler for the ring of KERNEL_W+1 line buffers in front of the conv block.
//   Upstream pixels are steered into one line buffer at a time. The KERNEL_W
//   oldest complete lines are read out together as one window line, and a line's
//   storage is released once the window has passed it. Applies backpressure
//   upstream when every buffer holds unconsumed data.
// PARAMETERS
//   DATA_W     8    pixel width; used only for consistency checks and assertions
//   KERNEL_W   3    kernel height = number of lines read per window (>=2)
//   RESOLUTION 512  pixels per line (>=2)
//   (local) NUM_LB = KERNEL_W+1; PTR_W = $clog2(NUM_LB); CNT_W = $clog2(NUM_LB*RESOLUTION+1)
// PORTS
//   clk_i          in   1         clock; all state updates on rising edge
//   arst_n_i       in   1         asynchronous reset, active-low
//   pix_valid_i    in   1         upstream pixel valid
//   pix_ready_o    out  1         upstream may transfer (transfer = valid & ready)
//   lb_wr_valid_o  out  NUM_LB    one-hot write strobe to line buffer [wr_ptr]
//   lb_rd_valid_o  out  NUM_LB    read strobes; KERNEL_W bits set while reading
//   rd_sel_o       out  PTR_W     index of the oldest (top) line of the window, for the output mux
//   window_valid_o out  1         a window column is being read this cycle
//   line_done_o    out  1         1-cycle pulse after the last column of a window line
//   fill_cnt_o     out  CNT_W     pixels buffered and not yet released
// BEHAVIOUR
//   Reset (async, arst_n_i=0): wr_ptr, wr_col, rd_ptr, rd_col and fill_cnt are 0.
//     FSM=IDLE. Outputs: pix_ready_o=1 after release, all others 0.
//     Reset mid-operation aborts the window; no partial-line state survives.
//   Write side:
//     pix_ready_o = (fill_cnt < NUM_LB*RESOLUTION); combinational from registered fill_cnt.
//     lb_wr_valid_o[wr_ptr] = pix_valid_i & pix_ready_o; all other bits are 0. Combinational.
//     On transfer: wr_col++. When wr_col==RESOLUTION-1: wr_col->0 and wr_ptr->(wr_ptr+1)%NUM_LB.
//   FSM:
//     IDLE: outputs quiet. -> READ when fill_cnt >= KERNEL_W*RESOLUTION.
//     READ: window_valid_o=1. lb_rd_valid_o bits (rd_ptr+k)%NUM_LB = 1 for k=0..KERNEL_W-1.
//       rd_sel_o=rd_ptr. rd_col++ each cycle (no stall; reader never waits).
//       At rd_col==RESOLUTION-1: rd_col->0, rd_ptr->(rd_ptr+1)%NUM_LB,
//       fill_cnt released by RESOLUTION, -> IDLE (one bubble cycle per line).
//   line_done_o: registered; high exactly one cycle after the final READ cycle of a line.
//   fill_cnt update: fill_cnt_next = fill_cnt + transfer - (release ? RESOLUTION : 0).
//     A transfer and a release in the same cycle are both applied.
//     fill_cnt never exceeds NUM_LB*RESOLUTION and never underflows.
//   Invariant: lb_wr_valid_o & lb_rd_valid_o == 0 every cycle. The write target is
//     never inside the active read window; the fill bound guarantees this.
//   Read data from the line buffers is registered, one cycle after the strobe;
//     conv alignment is the consumer's job. window_valid_o is not delayed here.
//   rd_sel_o holds its value in IDLE; it is don't-care for the consumer there.
// TESTING (RESOLUTION=8, KERNEL_W=3 unless noted)
//   1. Assert reset, release -> all outputs 0 except pix_ready_o=1.
//      Then hold pix_valid_i=0 for 20 cycles -> no strobes, fill_cnt_o=0.
//   2. Stream 24 pixels back-to-back -> lb_wr_valid_o = 0001 x8, 0010 x8, 0100 x8.
//      window_valid_o rises 2 cycles after pixel 24 is accepted.
//      lb_rd_valid_o=0111, rd_sel_o=0, for 8 cycles; then line_done_o pulses once.
//   3. pix_valid_i held high continuously for 200 cycles -> pix_ready_o=0 whenever fill_cnt_o==32.
//      Accepted count equals scoreboard count. Read/write strobe overlap is never observed.
//   4. Run 6 lines -> rd_sel_o sequence 0,1,2,3,0,1. lb_rd_valid_o sequence 0111,1110,1101,1011,...
//      Exactly one line_done_o per 8 window cycles.
//   5. Transfer on the same cycle as a release -> fill_cnt_o goes 24 -> 17.
//   6. Drop arst_n_i for 1 cycle at rd_col=4 -> all outputs 0 immediately, asynchronously.
//      The following 24 pixels reproduce scenario 2 exactly.

Source files
------------

// File: rtl/line_buffer_sched.sv
// line_buffer_sched: steers upstream pixels into a ring of KERNEL_W+1 line
// buffers and reads the KERNEL_W oldest complete lines out as one window line.
// Ports:
//   clk_i, arst_n_i            clock, async active-low reset
//   pix_valid_i, pix_ready_o   upstream pixel handshake
//   lb_wr_valid_o              one-hot write strobe to the current write buffer
//   lb_rd_valid_o              read strobes for the KERNEL_W window buffers
//   rd_sel_o                   index of the top (oldest) window line
//   window_valid_o             a window column is read this cycle
//   line_done_o                pulse one cycle after the last window column
//   fill_cnt_o                 pixels buffered and not yet released
module line_buffer_sched #(
    parameter int DATA_W     = 8,
    parameter int KERNEL_W   = 3,
    parameter int RESOLUTION = 512,
    localparam int NUM_LB    = KERNEL_W + 1,
    localparam int PTR_W     = $clog2(NUM_LB),
    localparam int CNT_W     = $clog2(NUM_LB * RESOLUTION + 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic [NUM_LB-1:0] lb_wr_valid_o,
    output logic [NUM_LB-1:0] lb_rd_valid_o,
    output logic [PTR_W-1:0]  rd_sel_o,
    output logic              window_valid_o,
    output logic              line_done_o,
    output logic [CNT_W-1:0]  fill_cnt_o
);

    localparam int COL_W = $clog2(RESOLUTION);

    localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(NUM_LB * RESOLUTION);
    localparam logic [CNT_W-1:0] FILL_START = CNT_W'(KERNEL_W * RESOLUTION);
    localparam logic [CNT_W-1:0] LINE_CNT   = CNT_W'(RESOLUTION);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(RESOLUTION - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_LB - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    generate
        if (KERNEL_W < 2 || RESOLUTION < 2 || DATA_W < 1) begin : g_bad_param
            $error("line_buffer_sched: illegal parameter set");
        end
    endgenerate

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [COL_W-1:0] wr_col_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [COL_W-1:0] rd_col_q;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic             done_q;
    logic             run_q;

    logic             xfer;
    logic             line_rel;
    logic [PTR_W-1:0] rd_prev;
    logic [NUM_LB-1:0] rd_mask;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // run_q keeps the upstream interface closed while reset is held
    // and opens it on the first clock edge after release.
    assign pix_ready_o = run_q && (fill_q < FILL_MAX);
    assign xfer        = pix_valid_i & pix_ready_o;

    assign lb_wr_valid_o = xfer ? (NUM_LB'(1) << wr_ptr_q) : '0;

    assign line_rel = (state_q == S_READ) && (rd_col_q == COL_LAST);

    // The window covers every buffer but the one just before rd_ptr,
    // which is the buffer the writer is filling while a window is read.
    assign rd_prev = (rd_ptr_q == '0) ? PTR_LAST : rd_ptr_q - PTR_W'(1);
    assign rd_mask = ~(NUM_LB'(1) << rd_prev);

    assign lb_rd_valid_o  = (state_q == S_READ) ? rd_mask : '0;
    assign window_valid_o = (state_q == S_READ);
    assign rd_sel_o       = rd_ptr_q;
    assign line_done_o    = done_q;
    assign fill_cnt_o     = fill_q;

    // Transfer and release in the same cycle both apply.
    assign fill_d = fill_q
                  + {{(CNT_W-1){1'b0}}, xfer}
                  - (line_rel ? LINE_CNT : '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (fill_q >= FILL_START) state_d = S_READ;
            S_READ: if (line_rel) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            wr_col_q <= '0;
            rd_ptr_q <= '0;
            rd_col_q <= '0;
            fill_q   <= '0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            fill_q  <= fill_d;
            done_q  <= line_rel;
            if (xfer) begin
                if (wr_col_q == COL_LAST) begin
                    wr_col_q <= '0;
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end else begin
                    wr_col_q <= wr_col_q + COL_W'(1);
                end
            end
            if (state_q == S_READ) begin
                if (line_rel) begin
                    rd_col_q <= '0;
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end else begin
                    rd_col_q <= rd_col_q + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_n_i) begin
            assert ((lb_wr_valid_o & lb_rd_valid_o) == '0);
            assert (fill_q <= FILL_MAX);
        end
    end

endmodule

// File: tb/tb_line_buffer_sched.sv
// tb_line_buffer_sched: scoreboard bench for line_buffer_sched
// (RESOLUTION=8, KERNEL_W=3).
module tb_line_buffer_sched;

    localparam int RES = 8;
    localparam int KW  = 3;
    localparam int NLB = 4;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [3:0] lb_wr_valid;
    logic [3:0] lb_rd_valid;
    logic [1:0] rd_sel;
    logic       window_valid;
    logic       line_done;
    logic [5:0] fill_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] wr_q[$];
    logic [5:0] rd_q[$];
    int done_exp = 0;
    int win_cnt = 0;
    int done_seen = 0;
    int acc_cnt = 0;
    bit mon_on = 0;
    bit sb_on = 0;
    bit saw_full = 0;

    logic [3:0] wr_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] rd_tab [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};

    line_buffer_sched #(
        .DATA_W    (8),
        .KERNEL_W  (KW),
        .RESOLUTION(RES)
    ) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .pix_valid_i   (pix_valid),
        .pix_ready_o   (pix_ready),
        .lb_wr_valid_o (lb_wr_valid),
        .lb_rd_valid_o (lb_rd_valid),
        .rd_sel_o      (rd_sel),
        .window_valid_o(window_valid),
        .line_done_o   (line_done),
        .fill_cnt_o    (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_ready);
        check({tag, "_ready"}, pix_ready, exp_ready);
        check({tag, "_wr"}, lb_wr_valid, 0);
        check({tag, "_rd"}, lb_rd_valid, 0);
        check({tag, "_sel"}, rd_sel, 0);
        check({tag, "_win"}, window_valid, 0);
        check({tag, "_done"}, line_done, 0);
        check({tag, "_fill"}, fill_cnt, 0);
    endtask

    task automatic push_writes(input int first, input int nlines);
        for (int l = 0; l < nlines; l++)
            for (int c = 0; c < RES; c++)
                wr_q.push_back(wr_tab[(first + l) % NLB]);
    endtask

    task automatic push_reads(input int first, input int nlines);
        for (int l = 0; l < nlines; l++)
            for (int c = 0; c < RES; c++)
                rd_q.push_back({rd_tab[(first + l) % NLB],
                                2'((first + l) % NLB)});
        done_exp += nlines;
    endtask

    task automatic do_reset(input bit chk);
        mon_on = 0;
        pix_valid = 1'b0;
        arst_n = 1'b0;
        wr_q.delete();
        rd_q.delete();
        done_exp = 0;
        win_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        if (chk) check_quiet("rst_hold", 1'b0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        if (chk) check_quiet("rst_rel", 1'b1);
        mon_on = 1;
    endtask

    task automatic send(input int n);
        int sent = 0;
        int g = 0;
        bit acc;
        pix_valid = 1'b1;
        while (sent < n && g < 2000) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            g++;
            if (acc) sent++;
        end
        pix_valid = 1'b0;
        check("send_count", sent, n);
    endtask

    task automatic wait_window(input string tag);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!window_valid && g < 20);
        check({tag, "_window_seen"}, window_valid, 1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || done_exp != 0)
               && g < 600) begin
            @(posedge clk);
            g++;
        end
        repeat (20) @(posedge clk);
        #1;
        check("drain_wr_q", wr_q.size(), 0);
        check("drain_rd_q", rd_q.size(), 0);
        check("drain_done", done_exp, 0);
    endtask

    task automatic scen_basic();
        int n = 0;
        sb_on = 1;
        push_writes(0, 3);
        push_reads(0, 1);
        send(24);
        do begin
            @(negedge clk);
            n++;
        end while (!window_valid && n < 10);
        check("window_latency", n, 2);
        wait_drain();
        check("fill_after_line", fill_cnt, 16);
    endtask

    always @(negedge clk) begin
        if (arst_n && mon_on) begin
            check("rw_overlap", lb_wr_valid & lb_rd_valid, 0);
            check("ready_rule", pix_ready, fill_cnt < 6'd32);
            if (fill_cnt == 6'd32) saw_full = 1;
            if (pix_valid && pix_ready) acc_cnt++;
            if (lb_wr_valid != 4'b0000) begin
                check("wr_onehot", $onehot(lb_wr_valid), 1);
                if (sb_on) begin
                    check("wr_expected", wr_q.size() != 0, 1);
                    if (wr_q.size() != 0)
                        check("wr_strobe", lb_wr_valid, wr_q.pop_front());
                end
            end
            if (window_valid) begin
                win_cnt++;
                if (sb_on) begin
                    check("rd_expected", rd_q.size() != 0, 1);
                    if (rd_q.size() != 0)
                        check("rd_window", {lb_rd_valid, rd_sel},
                              rd_q.pop_front());
                end
            end else begin
                check("rd_quiet", lb_rd_valid, 0);
            end
            if (line_done) begin
                check("done_spacing", win_cnt, 8);
                win_cnt = 0;
                done_seen++;
                if (sb_on) begin
                    check("done_expected", done_exp > 0, 1);
                    if (done_exp > 0) done_exp--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // reset state, then idle input
        do_reset(1);
        sb_on = 1;
        repeat (20) @(posedge clk);
        #1;
        check("s1_fill", fill_cnt, 0);

        // 24 pixels, one window line
        do_reset(0);
        scen_basic();

        // continuous valid with backpressure
        do_reset(0);
        sb_on = 0;
        acc_cnt = 0;
        done_seen = 0;
        saw_full = 0;
        pix_valid = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("s3_backpressure", saw_full, 1);
        check("s3_conservation", fill_cnt, acc_cnt - RES * done_seen);
        check("s3_idle_below", fill_cnt < 6'd24, 1);
        check("s3_window_off", window_valid, 0);

        // six window lines around the ring
        do_reset(0);
        sb_on = 1;
        done_seen = 0;
        push_writes(0, 8);
        push_reads(0, 6);
        send(64);
        wait_drain();
        check("s4_done_count", done_seen, 6);
        check("s4_fill", fill_cnt, 16);

        // transfer coincident with release
        do_reset(0);
        sb_on = 1;
        push_writes(0, 3);
        push_reads(0, 1);
        wr_q.push_back(4'b1000);
        send(24);
        wait_window("s5");
        repeat (7) @(posedge clk);
        #1;
        check("s5_fill_before", fill_cnt, 24);
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("s5_fill_after", fill_cnt, 17);
        check("s5_done_pulse", line_done, 1);
        wait_drain();
        check("s5_fill_final", fill_cnt, 17);

        // async reset in the middle of a window
        do_reset(0);
        sb_on = 1;
        push_writes(0, 3);
        push_reads(0, 1);
        send(24);
        wait_window("s6");
        repeat (4) @(posedge clk);
        #2;
        arst_n = 1'b0;
        mon_on = 0;
        #1;
        check_quiet("s6_abort", 1'b0);
        wr_q.delete();
        rd_q.delete();
        done_exp = 0;
        win_cnt = 0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1;
        check_quiet("s6_release", 1'b1);
        scen_basic();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
